// File: rtl/booth_radix4_mult.sv
// booth_radix4_mult: iterative radix-4 Booth multiplier, two multiplier bits
// retired per clock, start/busy/done handshake with back-to-back restart.
// Optional feature macro: BOOTH_UNSIGNED_MODE_EN adds the signed_op port and
// zero-extended (unsigned) operation with one extra Booth digit.
module booth_radix4_mult #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multA,
    input  logic [WIDTH-1:0]   multB,
`ifdef BOOTH_UNSIGNED_MODE_EN
    input  logic               signed_op,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    // A carries two guard bits over the extended operand so +/-2M cannot overflow
    localparam int AW = WIDTH + 4;
    localparam int QW = WIDTH + 2;
    localparam int FW = AW + QW + 1;
    localparam int NS = WIDTH / 2;
    localparam int NU = WIDTH / 2 + 1;
    localparam int CW = $clog2(NU + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [AW-1:0]      a_q;
    logic [QW-1:0]      q_q;
    logic               qm1_q;
    logic [QW-1:0]      m_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] prod_q;
`ifdef BOOTH_UNSIGNED_MODE_EN
    logic               uns_q;
`endif

    logic               accept;
    logic               last_iter;
    logic [CW-1:0]      last_cnt;
    logic [QW-1:0]      m_ext, q_ext;
    logic [AW-1:0]      m_w, m2_w, addend, a_sum;
    logic [FW-1:0]      full_w, sh_w;
    logic [2*WIDTH-1:0] prod_nx;

    // A start is honoured only when no operation is iterating
    assign accept    = start && (state_q != S_RUN);
    assign last_iter = (state_q == S_RUN) && (cnt_q == last_cnt);

    // Operand extension: sign-extend by default, zero-extend for unsigned ops
    always_comb begin
        m_ext = {{2{multA[WIDTH-1]}}, multA};
        q_ext = {{2{multB[WIDTH-1]}}, multB};
`ifdef BOOTH_UNSIGNED_MODE_EN
        if (!signed_op) begin
            m_ext = {2'b00, multA};
            q_ext = {2'b00, multB};
        end
`endif
    end

    // Unsigned ops need one more digit to consume the zero-extension bits
`ifdef BOOTH_UNSIGNED_MODE_EN
    assign last_cnt = uns_q ? CW'(NU - 1) : CW'(NS - 1);
`else
    assign last_cnt = CW'(NS - 1);
`endif

    // Booth digit select and accumulate, then arithmetic shift by two
    always_comb begin
        m_w  = {{2{m_q[QW-1]}}, m_q};
        m2_w = m_w << 1;
        case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: addend = m_w;
            3'b011:         addend = m2_w;
            3'b100:         addend = -m2_w;
            3'b101, 3'b110: addend = -m_w;
            default:        addend = '0;
        endcase
        a_sum  = a_q + addend;
        full_w = {a_sum, q_q, qm1_q};
        sh_w   = $signed(full_w) >>> 2;
    end

    // After the final shift the product sits two bits higher in {A,Q} when
    // only WIDTH/2 digits were retired (Q still holds its two extension bits)
`ifdef BOOTH_UNSIGNED_MODE_EN
    assign prod_nx = uns_q ? sh_w[2*WIDTH:1] : sh_w[2*WIDTH+2:3];
`else
    assign prod_nx = sh_w[2*WIDTH+2:3];
`endif

    // Next-state logic for IDLE -> RUN -> DONE, with restart from DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q == last_cnt) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Datapath: load on accept, iterate in RUN, capture product on the last step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            q_q    <= '0;
            qm1_q  <= 1'b0;
            m_q    <= '0;
            cnt_q  <= '0;
            prod_q <= '0;
`ifdef BOOTH_UNSIGNED_MODE_EN
            uns_q  <= 1'b0;
`endif
        end else if (accept) begin
            a_q    <= '0;
            q_q    <= q_ext;
            qm1_q  <= 1'b0;
            m_q    <= m_ext;
            cnt_q  <= '0;
`ifdef BOOTH_UNSIGNED_MODE_EN
            uns_q  <= ~signed_op;
`endif
        end else if (state_q == S_RUN) begin
            a_q   <= sh_w[FW-1:QW+1];
            q_q   <= sh_w[QW:1];
            qm1_q <= sh_w[0];
            cnt_q <= cnt_q + CW'(1);
            if (last_iter) prod_q <= prod_nx;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign product = prod_q;

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Self-checking bench for booth_radix4_mult: one WIDTH=8 and one WIDTH=16
// instance sharing clock and reset, checked against plain integer multiply.
module tb_booth_radix4_mult;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        st8 = 1'b0, st16 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        sop8 = 1'b1, sop16 = 1'b1;
    logic        busy8, done8, busy16, done16;
    logic [15:0] prod8;
    logic [31:0] prod16;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    booth_radix4_mult #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(st8), .multA(a8), .multB(b8),
`ifdef BOOTH_UNSIGNED_MODE_EN
        .signed_op(sop8),
`endif
        .busy(busy8), .done(done8), .product(prod8));

    booth_radix4_mult #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(st16), .multA(a16), .multB(b16),
`ifdef BOOTH_UNSIGNED_MODE_EN
        .signed_op(sop16),
`endif
        .busy(busy16), .done(done16), .product(prod16));

    // Reference: integer multiply of the operands interpreted per mode
    function automatic longint ref_mul(input longint a, input longint b, input int w, input bit uns);
        longint r;
        if (!uns) begin
            if (a >= (64'sd1 <<< (w - 1))) a = a - (64'sd1 <<< w);
            if (b >= (64'sd1 <<< (w - 1))) b = b - (64'sd1 <<< w);
        end
        r = a * b;
        return r & ((64'sd1 <<< (2 * w)) - 1);
    endfunction

    // Accept one 8-bit op, return edges-to-done (accept edge = 1), product,
    // and whether done was still high one edge later
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sop,
                       output int lat, output logic [15:0] p, output logic done_after);
        @(negedge clk);
        a8 = a; b8 = b; sop8 = sop; st8 = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0;
        lat = -1; p = 'x;
        for (int k = 1; k <= 20; k++) begin
            if (done8) begin lat = k; p = prod8; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        done_after = done8;
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic sop,
                        output int lat, output logic [31:0] p);
        @(negedge clk);
        a16 = a; b16 = b; sop16 = sop; st16 = 1'b1;
        @(posedge clk); #1;
        st16 = 1'b0;
        lat = -1; p = 'x;
        for (int k = 1; k <= 30; k++) begin
            if (done16) begin lat = k; p = prod16; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        #2;
        tests++; if (busy8 !== 1'b0)  begin fails++; $display("FAIL reset_busy8 got=%b exp=0", busy8); end
        tests++; if (done8 !== 1'b0)  begin fails++; $display("FAIL reset_done8 got=%b exp=0", done8); end
        tests++; if (prod8 !== 16'h0) begin fails++; $display("FAIL reset_prod8 got=%h exp=0", prod8); end
        tests++; if (prod16 !== 32'h0) begin fails++; $display("FAIL reset_prod16 got=%h exp=0", prod16); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin fails++; $display("FAIL idle_after_reset busy=%b done=%b exp=0/0", busy8, done8); end
    endtask

    task automatic test_basic();
        int lat; logic [15:0] p; logic da; logic [15:0] held;
        op8(8'd7, 8'hFD, 1'b1, lat, p, da);
        tests++; if (p !== 16'hFFEB) begin fails++; $display("FAIL basic_7x-3 got=%h exp=ffeb", p); end
        tests++; if (lat !== 5) begin fails++; $display("FAIL basic_latency got=%0d exp=5", lat); end
        tests++; if (da !== 1'b0) begin fails++; $display("FAIL basic_done_width done_next=%b exp=0", da); end
        held = prod8;
        repeat (3) @(posedge clk); #1;
        tests++; if (prod8 !== 16'hFFEB || held !== 16'hFFEB) begin fails++; $display("FAIL basic_hold got=%h exp=ffeb", prod8); end
    endtask

    task automatic test_corners();
        logic [7:0]  ca [3] = '{8'h80, 8'h7F, 8'h00};
        logic [7:0]  cb [3] = '{8'h80, 8'h80, 8'hFF};
        logic [15:0] ce [3] = '{16'h4000, 16'hC080, 16'h0000};
        int lat; logic [15:0] p; logic da;
        for (int i = 0; i < 3; i++) begin
            op8(ca[i], cb[i], 1'b1, lat, p, da);
            tests++; if (p !== ce[i]) begin fails++; $display("FAIL corner_%0d got=%h exp=%h", i, p, ce[i]); end
        end
    endtask

    task automatic test_start_during_run();
        int lat;
        @(negedge clk);
        a8 = 8'd5; b8 = 8'd6; sop8 = 1'b1; st8 = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        a8 = 8'd99; b8 = 8'hF0; st8 = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0;
        tests++; if (prod8 !== 16'h0000) begin fails++; $display("FAIL run_prod_stable got=%h exp=0000", prod8); end
        lat = -1;
        for (int k = 3; k <= 20; k++) begin
            if (done8) begin lat = k; break; end
            @(posedge clk); #1;
        end
        tests++; if (lat !== 5) begin fails++; $display("FAIL ignore_start_latency got=%0d exp=5", lat); end
        tests++; if (prod8 !== 16'd30) begin fails++; $display("FAIL ignore_start_prod got=%h exp=001e", prod8); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        a8 = 8'hF6; b8 = 8'd12; sop8 = 1'b1; st8 = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            if (done8) begin lat = k; break; end
            @(posedge clk); #1;
        end
        tests++; if (prod8 !== 16'hFF88) begin fails++; $display("FAIL b2b_first got=%h exp=ff88", prod8); end
        a8 = 8'd13; b8 = 8'hF9; st8 = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0;
        tests++; if (busy8 !== 1'b1) begin fails++; $display("FAIL b2b_no_gap busy=%b exp=1", busy8); end
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            if (done8) begin lat = k; break; end
            @(posedge clk); #1;
        end
        tests++; if (lat !== 5) begin fails++; $display("FAIL b2b_latency got=%0d exp=5", lat); end
        tests++; if (prod8 !== 16'hFFA5) begin fails++; $display("FAIL b2b_second got=%h exp=ffa5", prod8); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_abort();
        int lat; logic [15:0] p; logic da; int seen;
        @(negedge clk);
        a8 = 8'd11; b8 = 8'd9; sop8 = 1'b1; st8 = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++; if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0)
            begin fails++; $display("FAIL abort_clear busy=%b done=%b prod=%h exp=0/0/0", busy8, done8, prod8); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done8) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL abort_no_done pulses=%0d exp=0", seen); end
        op8(8'd11, 8'd9, 1'b1, lat, p, da);
        tests++; if (p !== 16'd99 || lat !== 5) begin fails++; $display("FAIL abort_restart got=%h lat=%0d exp=0063 lat=5", p, lat); end
    endtask

`ifdef BOOTH_UNSIGNED_MODE_EN
    task automatic test_unsigned();
        int lat; logic [15:0] p; logic da; logic [7:0] ra, rb; logic rs;
        op8(8'hFF, 8'hFF, 1'b0, lat, p, da);
        tests++; if (p !== 16'hFE01 || lat !== 6) begin fails++; $display("FAIL uns_255x255 got=%h lat=%0d exp=fe01 lat=6", p, lat); end
        op8(8'hFF, 8'hFF, 1'b1, lat, p, da);
        tests++; if (p !== 16'h0001 || lat !== 5) begin fails++; $display("FAIL sgn_-1x-1 got=%h lat=%0d exp=0001 lat=5", p, lat); end
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
            op8(ra, rb, rs, lat, p, da);
            tests++;
            if (p !== 16'(ref_mul(longint'(ra), longint'(rb), 8, !rs)) || lat !== (rs ? 5 : 6)) begin
                fails++; $display("FAIL rand8 a=%h b=%h s=%b got=%h lat=%0d exp=%h", ra, rb, rs, p, lat,
                                  16'(ref_mul(longint'(ra), longint'(rb), 8, !rs)));
            end
        end
    endtask
`endif

    task automatic test_wide();
        int lat; logic [31:0] p; logic [15:0] ra, rb; logic [31:0] e;
        op16(16'h8000, 16'h7FFF, 1'b1, lat, p);
        tests++; if (p !== 32'hC0008000 || lat !== 9) begin fails++; $display("FAIL w16_corner got=%h lat=%0d exp=c0008000 lat=9", p, lat); end
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom);
            e  = 32'(ref_mul(longint'(ra), longint'(rb), 16, 1'b0));
            op16(ra, rb, 1'b1, lat, p);
            tests++;
            if (p !== e || lat !== 9) begin
                fails++; $display("FAIL w16_rand a=%h b=%h got=%h lat=%0d exp=%h", ra, rb, p, lat, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_start_during_run();
        test_back_to_back();
        test_reset_abort();
`ifdef BOOTH_UNSIGNED_MODE_EN
        test_unsigned();
`endif
        test_wide();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
